uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_meta_harden.sv | 25 ++
 rtl/uart_rx.sv | 112 +++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants,
// also used by the 16x baud-enable generator.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/uart_meta_harden.sv
// Multi-flop synchronizer for an asynchronous input; all stages reset to 1
// so an idle-high line never looks like a start bit coming out of reset.
`timescale 1ns/1ps
module uart_meta_harden #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start-bit validation at mid-bit, LSB-first
// data capture, stop-bit check and a one-clock ready pulse per frame.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_x16_en,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
    output logic       frm_err,
    output logic       rx_busy
);

    localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] OS_MID   = 4'(MID_SAMPLE);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    logic                 rxd_s;
    rx_state_t            state, state_nxt;
    logic [3:0]           os_cnt, os_cnt_nxt;
    logic [2:0]           bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_reg_nxt;
    logic [7:0]           rx_data_nxt;
    logic                 frm_err_nxt;
    logic                 rdy_nxt;

    uart_meta_harden #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_meta_harden (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxd_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data     <= '0;
            frm_err     <= 1'b0;
            rx_data_rdy <= 1'b0;
        end else begin
            state       <= state_nxt;
            os_cnt      <= os_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift_reg   <= shift_reg_nxt;
            rx_data     <= rx_data_nxt;
            frm_err     <= frm_err_nxt;
            rx_data_rdy <= rdy_nxt;
        end
    end

    // os_cnt free-runs and wraps 15->0, so DATA/STOP samples land 16 ticks apart at mid-bit.
    always_comb begin
        state_nxt     = state;
        os_cnt_nxt    = os_cnt;
        bit_cnt_nxt   = bit_cnt;
        shift_reg_nxt = shift_reg;
        rx_data_nxt   = rx_data;
        frm_err_nxt   = frm_err;
        rdy_nxt       = 1'b0;

        if (baud_x16_en) begin
            os_cnt_nxt = os_cnt + 4'd1;
            unique case (state)
                IDLE: begin
                    os_cnt_nxt = '0;
                    if (!rxd_s) begin
                        state_nxt = START;
                    end
                end
                START: begin
                    if (os_cnt == OS_MID) begin
                        os_cnt_nxt  = '0;
                        bit_cnt_nxt = '0;
                        state_nxt   = rxd_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (os_cnt == OS_LAST) begin
                        shift_reg_nxt = {rxd_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt_nxt   = bit_cnt + 3'd1;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = STOP;
                        end
                    end
                end
                STOP: begin
                    if (os_cnt == OS_LAST) begin
                        state_nxt   = IDLE;
                        rx_data_nxt = 8'(shift_reg);
                        frm_err_nxt = !rxd_s;
                        rdy_nxt     = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: 8-bit and 7-bit instances,
// baud_x16_en every 4 clk (64 clk per bit).
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       baud_x16_en;
    logic       rxd;
    logic       rxd7;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       frm_err;
    logic       rx_busy;
    logic [7:0] rx_data7;
    logic       rx_data_rdy7;
    logic       frm_err7;
    logic       rx_busy7;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_div = 0;
    int pulse_cnt = 0;
    int pulse_cnt7 = 0;
    logic [7:0] pulse_data [0:15];
    int         pulse_time [0:15];

    uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_x16_en (baud_x16_en),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .frm_err     (frm_err),
        .rx_busy     (rx_busy)
    );

    uart_rx #(.DATA_BITS(7), .SYNC_STAGES(2)) dut7 (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_x16_en (baud_x16_en),
        .rxd         (rxd7),
        .rx_data     (rx_data7),
        .rx_data_rdy (rx_data_rdy7),
        .frm_err     (frm_err7),
        .rx_busy     (rx_busy7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        baud_x16_en = 1'b0;
        forever begin
            @(negedge clk);
            tick_div = tick_div + 1;
            baud_x16_en = ((tick_div % 4) == 0);
        end
    end

    // Ready pulses are recorded mid-cycle so each one-clk pulse is counted once.
    always @(negedge clk) begin
        if (rx_data_rdy) begin
            if (pulse_cnt < 16) begin
                pulse_data[pulse_cnt] = rx_data;
                pulse_time[pulse_cnt] = cyc;
            end
            pulse_cnt = pulse_cnt + 1;
        end
        if (rx_data_rdy7) begin
            pulse_cnt7 = pulse_cnt7 + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveBit(input logic value, input bit on7);
        @(negedge clk);
        if (on7) rxd7 = value;
        else     rxd  = value;
        repeat (63) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input int nbits, input bit on7);
        driveBit(1'b0, on7);
        for (int i = 0; i < nbits; i++) begin
            driveBit(data[i], on7);
        end
        driveBit(stop_bit, on7);
    endtask

    initial begin
        int base;
        int base7;
        logic [7:0] abort_byte;

        rst_n = 1'b0;
        rxd   = 1'b1;
        rxd7  = 1'b1;
        abort_byte = 8'h81;
        repeat (5) @(negedge clk);
        checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
        checkOutput("reset_rdy", 32'(rx_data_rdy), 32'h0);
        checkOutput("reset_frm_err", 32'(frm_err), 32'h0);
        checkOutput("reset_busy", 32'(rx_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("[TB] clean frame 0xA5");
        base = pulse_cnt;
        applyStimulus(8'hA5, 1'b1, 8, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("a5_pulses", 32'(pulse_cnt - base), 32'd1);
        checkOutput("a5_data", 32'(rx_data), 32'hA5);
        checkOutput("a5_frm_err", 32'(frm_err), 32'h0);
        checkOutput("a5_busy", 32'(rx_busy), 32'h0);

        $display("[TB] framing error on 0x3C, then clean 0x00");
        base = pulse_cnt;
        applyStimulus(8'h3C, 1'b0, 8, 1'b0);
        @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("3c_pulses", 32'(pulse_cnt - base), 32'd1);
        checkOutput("3c_data", 32'(rx_data), 32'h3C);
        checkOutput("3c_frm_err", 32'(frm_err), 32'h1);
        base = pulse_cnt;
        applyStimulus(8'h00, 1'b1, 8, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("00_pulses", 32'(pulse_cnt - base), 32'd1);
        checkOutput("00_data", 32'(rx_data), 32'h00);
        checkOutput("00_frm_err", 32'(frm_err), 32'h0);

        $display("[TB] 16-clk glitch on idle line");
        base = pulse_cnt;
        @(negedge clk);
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("glitch_busy_high", 32'(rx_busy), 32'h1);
        repeat (6) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("glitch_pulses", 32'(pulse_cnt - base), 32'd0);
        checkOutput("glitch_data", 32'(rx_data), 32'h00);
        checkOutput("glitch_busy_low", 32'(rx_busy), 32'h0);

        $display("[TB] back-to-back 0x55, 0xFF");
        base = pulse_cnt;
        applyStimulus(8'h55, 1'b1, 8, 1'b0);
        applyStimulus(8'hFF, 1'b1, 8, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("b2b_pulses", 32'(pulse_cnt - base), 32'd2);
        if (pulse_cnt - base == 2 && base + 1 < 16) begin
            checkOutput("b2b_first", 32'(pulse_data[base]), 32'h55);
            checkOutput("b2b_second", 32'(pulse_data[base + 1]), 32'hFF);
            checkOutput("b2b_spacing", 32'(pulse_time[base + 1] - pulse_time[base]), 32'd640);
        end

        $display("[TB] reset during data bit 4 of 0x81, then 0x7E");
        base = pulse_cnt;
        driveBit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            driveBit(abort_byte[i], 1'b0);
        end
        @(negedge clk);
        rxd = abort_byte[4];
        repeat (31) @(negedge clk);
        checkOutput("abort_busy_before", 32'(rx_busy), 32'h1);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("abort_busy_reset", 32'(rx_busy), 32'h0);
        checkOutput("abort_data_reset", 32'(rx_data), 32'h00);
        checkOutput("abort_rdy_reset", 32'(rx_data_rdy), 32'h0);
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("abort_no_pulse", 32'(pulse_cnt - base), 32'd0);
        base = pulse_cnt;
        applyStimulus(8'h7E, 1'b1, 8, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("7e_pulses", 32'(pulse_cnt - base), 32'd1);
        checkOutput("7e_data", 32'(rx_data), 32'h7E);
        checkOutput("7e_frm_err", 32'(frm_err), 32'h0);

        $display("[TB] 7-bit frame 0x5A");
        base7 = pulse_cnt7;
        applyStimulus(8'h5A, 1'b1, 7, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("d7_pulses", 32'(pulse_cnt7 - base7), 32'd1);
        checkOutput("d7_data", 32'(rx_data7), 32'h5A);
        checkOutput("d7_bit7", 32'(rx_data7[7]), 32'h0);
        checkOutput("d7_frm_err", 32'(frm_err7), 32'h0);
        checkOutput("d7_busy", 32'(rx_busy7), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
